// File: rtl/dispatch.sv
// Dispatch buffer between rename and the ALU/MEM/BR issue queues.
// Holds renamed instructions in a circular FIFO and issues up to two per cycle in order.
package dispatch_pkg;
    localparam int TAG_WIDTH = 6;

    typedef struct packed {
        logic                 is_renamed;
        logic [TAG_WIDTH-1:0] tag;
        logic [31:0]          data;
    } src_t;

    typedef struct packed {
        logic                 is_valid;
        logic [6:0]           opcode;
        logic [TAG_WIDTH-1:0] dest_tag;
        logic [31:0]          pc;
        src_t                 src_0_a;
        src_t                 src_0_b;
        src_t                 src_1_a;
        src_t                 src_1_b;
    } instruction_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        logic [31:0]          data;
    } cdb_t;

    localparam int INST_W = $bits(instruction_t);
    localparam int CDB_W  = $bits(cdb_t);

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_MEM = 2'd1,
        CLS_BR  = 2'd2
    } iq_class_e;

    // Unknown opcodes land on the ALU queue so nothing ever stalls forever.
    function automatic iq_class_e decode_class(input logic [6:0] opcode);
        iq_class_e c;
        case (opcode)
            OPC_LOAD, OPC_STORE:            c = CLS_MEM;
            OPC_BRANCH, OPC_JAL, OPC_JALR:  c = CLS_BR;
            default:                        c = CLS_ALU;
        endcase
        return c;
    endfunction
endpackage

module dispatch
    import dispatch_pkg::*;
#(
    parameter int PIPE_WIDTH = 2,
    parameter int BUF_DEPTH  = 4,
    parameter int CDB_PORTS  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    output logic                         dispatch_rdy,
    input  logic [PIPE_WIDTH*INST_W-1:0] renamed_insts,
    input  logic [CDB_PORTS*CDB_W-1:0]   cdb_ports,
    output logic [PIPE_WIDTH*INST_W-1:0] alu_iq_insts,
    output logic [PIPE_WIDTH*INST_W-1:0] mem_iq_insts,
    output logic [PIPE_WIDTH*INST_W-1:0] br_iq_insts,
    input  logic                         alu_iq_rdy,
    input  logic                         mem_iq_rdy,
    input  logic                         br_iq_rdy
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [PTR_W:0]   RDY_MAX = (PTR_W+1)'(BUF_DEPTH - 2);
    localparam logic [PTR_W:0]   CNT_TWO = (PTR_W+1)'(2);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    generate
        if (PIPE_WIDTH != 2) begin : g_bad_pipe_width
            $error("dispatch: PIPE_WIDTH must be 2");
        end
        if (BUF_DEPTH < 4 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_buf_depth
            $error("dispatch: BUF_DEPTH must be a power of two >= 4");
        end
    endgenerate

    instruction_t buf_q [BUF_DEPTH];
    instruction_t buf_d [BUF_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0] head_nxt, tail_slot1;
    logic [PTR_W:0]   count_q, count_d;

    instruction_t in_inst [PIPE_WIDTH];
    instruction_t in_woken [PIPE_WIDTH];
    instruction_t h0, h1;
    iq_class_e    cls0, cls1;
    logic         rdy0, rdy1;
    logic         h0_go, h1_go, enq_ok, h1_lane;
    logic [1:0]   n_disp, n_enq;

    instruction_t alu_l [PIPE_WIDTH];
    instruction_t mem_l [PIPE_WIDTH];
    instruction_t br_l  [PIPE_WIDTH];

    // Lowest-indexed CDB port wins: scan high to low so lower ports overwrite.
    function automatic src_t wake_src(input src_t s, input logic [CDB_PORTS*CDB_W-1:0] cdb);
        src_t r;
        cdb_t c;
        r = s;
        if (s.is_renamed) begin
            for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                c = cdb[p*CDB_W +: CDB_W];
                if (c.valid && c.tag == s.tag) begin
                    r.is_renamed = 1'b0;
                    r.data       = c.data;
                end
            end
        end
        return r;
    endfunction

    function automatic instruction_t wake_inst(input instruction_t x,
                                               input logic [CDB_PORTS*CDB_W-1:0] cdb);
        instruction_t r;
        r         = x;
        r.src_0_a = wake_src(x.src_0_a, cdb);
        r.src_0_b = wake_src(x.src_0_b, cdb);
        r.src_1_a = wake_src(x.src_1_a, cdb);
        r.src_1_b = wake_src(x.src_1_b, cdb);
        return r;
    endfunction

    function automatic logic class_rdy(input iq_class_e c, input logic a, input logic m,
                                       input logic b);
        logic r;
        case (c)
            CLS_MEM: r = m;
            CLS_BR:  r = b;
            default: r = a;
        endcase
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_WIDTH; gi++) begin : g_lanes
            assign in_inst[gi]                       = renamed_insts[gi*INST_W +: INST_W];
            assign in_woken[gi]                      = wake_inst(in_inst[gi], cdb_ports);
            assign alu_iq_insts[gi*INST_W +: INST_W] = alu_l[gi];
            assign mem_iq_insts[gi*INST_W +: INST_W] = mem_l[gi];
            assign br_iq_insts[gi*INST_W +: INST_W]  = br_l[gi];
        end
    endgenerate

    // Depends only on registered state, so upstream never sees a path from the queues.
    assign dispatch_rdy = !rst && (count_q <= RDY_MAX);

    assign head_nxt = head_q + PTR_ONE;
    assign h0       = wake_inst(buf_q[head_q], cdb_ports);
    assign h1       = wake_inst(buf_q[head_nxt], cdb_ports);
    assign cls0     = decode_class(h0.opcode);
    assign cls1     = decode_class(h1.opcode);
    assign rdy0     = class_rdy(cls0, alu_iq_rdy, mem_iq_rdy, br_iq_rdy);
    assign rdy1     = class_rdy(cls1, alu_iq_rdy, mem_iq_rdy, br_iq_rdy);

    assign h0_go   = !flush && (count_q != '0) && rdy0;
    assign h1_go   = h0_go && (count_q >= CNT_TWO) && rdy1;
    assign h1_lane = (cls1 == cls0);
    assign n_disp  = {1'b0, h0_go} + {1'b0, h1_go};

    assign enq_ok     = dispatch_rdy && !flush;
    assign n_enq      = enq_ok ? ({1'b0, in_inst[0].is_valid} + {1'b0, in_inst[1].is_valid})
                               : 2'd0;
    assign tail_slot1 = tail_q + PTR_W'(in_inst[0].is_valid);

    always_comb begin
        alu_l = '{default: '0};
        mem_l = '{default: '0};
        br_l  = '{default: '0};
        if (h0_go) begin
            case (cls0)
                CLS_MEM: mem_l[0] = h0;
                CLS_BR:  br_l[0]  = h0;
                default: alu_l[0] = h0;
            endcase
        end
        if (h1_go) begin
            case (cls1)
                CLS_MEM: mem_l[h1_lane] = h1;
                CLS_BR:  br_l[h1_lane]  = h1;
                default: alu_l[h1_lane] = h1;
            endcase
        end
    end

    always_comb begin
        buf_d   = buf_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (buf_q[i].is_valid) begin
                buf_d[i] = wake_inst(buf_q[i], cdb_ports);
            end
        end
        if (flush) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_d[i].is_valid = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (h0_go) buf_d[head_q].is_valid   = 1'b0;
            if (h1_go) buf_d[head_nxt].is_valid = 1'b0;
            if (enq_ok && in_inst[0].is_valid) buf_d[tail_q]     = in_woken[0];
            if (enq_ok && in_inst[1].is_valid) buf_d[tail_slot1] = in_woken[1];
            head_d  = head_q + PTR_W'(n_disp);
            tail_d  = tail_q + PTR_W'(n_enq);
            count_d = count_q + (PTR_W+1)'(n_enq) - (PTR_W+1)'(n_disp);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: doc/dispatch.md
DISPATCH -- requirements
Module: dispatch

Interface
REQ-001 Parameter PIPE_WIDTH, default 2, instructions accepted and dispatched per cycle; the design SHALL support only 2.
REQ-002 Parameter BUF_DEPTH, default 4, dispatch buffer entries; SHALL be a power of two and at least 4.
REQ-003 Parameter CDB_PORTS, default 2, result broadcast ports snooped.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  synchronous pipeline flush.
REQ-007 dispatch_rdy  out  1  high when the buffer can accept 2 instructions this cycle.
REQ-008 renamed_insts  in  instruction_t[PIPE_WIDTH]  from rename; slot 0 is valid whenever any slot is valid.
REQ-009 cdb_ports  in  cdb_t[CDB_PORTS]  {valid, tag[TAG_WIDTH], data[31:0]}.
REQ-010 alu_iq_insts, mem_iq_insts, br_iq_insts  out  instruction_t[PIPE_WIDTH] each  per-queue dispatch lanes; lane valid is is_valid.
REQ-011 alu_iq_rdy, mem_iq_rdy, br_iq_rdy  in  1 each  the queue accepts up to 2 instructions this cycle.

Function
REQ-012 An instruction SHALL enter the buffer when its is_valid bit is set and dispatch_rdy was high in that cycle; instructions with is_valid low SHALL be discarded.
REQ-013 dispatch_rdy SHALL be a combinational function of registered state only: (free entries >= 2); it SHALL NOT depend on iq_rdy.
REQ-014 The buffer SHALL be a circular FIFO with head and tail pointers of log2(BUF_DEPTH) bits that wrap modulo BUF_DEPTH, plus a count of log2(BUF_DEPTH)+1 bits.
REQ-015 Queue class SHALL be decoded from opcode: OP, OP_IMM, LUI, AUIPC go to ALU; LOAD, STORE go to MEM; BRANCH, JAL, JALR go to BR; any other opcode goes to ALU.
REQ-016 Each cycle, head entry H0 SHALL dispatch when the buffer is non-empty and its class rdy is high.
REQ-017 Entry H1 (head+1) SHALL dispatch only when H0 dispatches, count >= 2, and the rdy of H1's class is high; dispatch is strictly in order.
REQ-018 Dispatched instructions SHALL drive lane 0 of their class queue first; when H0 and H1 share a class, H0 drives lane 0 and H1 drives lane 1.
REQ-019 All unused lanes SHALL present all-zero.
REQ-020 Dispatch SHALL be combinational from the buffer (0-cycle); an instruction entering at edge N SHALL be dispatchable in cycle N+1 at the earliest.
REQ-021 Head SHALL advance by the number dispatched; count SHALL change by (enqueued - dispatched), so simultaneous enqueue and dequeue are allowed.
REQ-022 Wakeup: for every buffered source (src_0_a, src_0_b, src_1_a, src_1_b) with is_renamed=1 whose tag matches a valid cdb_ports tag, the data SHALL be captured and is_renamed cleared at the edge.
REQ-023 Entries being enqueued SHALL snoop the CDB in the same cycle.
REQ-024 Dispatch lanes SHALL present the bypassed, already-woken operand values during a matching CDB cycle.
REQ-025 When several CDB ports match the same tag, the lowest-indexed port SHALL win.
REQ-026 Flush SHALL zero count, head and tail; it SHALL block dispatch and enqueue in that cycle and SHALL force all lanes to zero in that cycle.
REQ-027 A full buffer SHALL drop dispatch_rdy; an empty buffer SHALL present no valid lanes.

Reset
REQ-028 While rst is high: dispatch_rdy=0, all lanes zero, count/head/tail=0, and all entries' is_valid=0.
REQ-029 When rst is released: dispatch_rdy=1 in the first cycle.
REQ-030 Reset asserted mid-operation SHALL discard all buffered instructions immediately, without waiting for a clock edge.

Verification
REQ-031 Enqueue ADD,LW with all rdy=1 -> next cycle, ADD on alu lane0 and LW on mem lane0; count returns to 0.
REQ-032 Enqueue BEQ,JAL with br_iq_rdy=0 for 3 cycles -> no br lanes are valid; dispatch_rdy=1 with count=2, then 0 after a second pair (count=4); on rdy=1 both go on br lanes 0 and 1.
REQ-033 H0=ADD (alu_rdy=0), H1=LW (mem_rdy=1) -> neither dispatches (in-order).
REQ-034 Buffered ADD src_1_a tag=5 is_renamed=1, cdb[1]={1,5,0xDEADBEEF} -> same-cycle lane shows data 0xDEADBEEF with is_renamed=0; the entry is updated if not dispatched.
REQ-035 Fill 4, dispatch 1/cycle for 8 cycles while enqueuing 2 when ready -> pointers wrap; output order matches input order.
REQ-036 Flush with count=3 and simultaneous valid input -> count=0 next cycle; no lane is valid during flush; asynchronous rst mid-stream -> outputs zero before the next edge.
